// File: rtl/sa_psum_drain_pkg.sv
// Shared types and defaults for the systolic-array partial-sum drain.
package sa_psum_drain_pkg;

  localparam int SA_N_DEFAULT = 4;
  localparam int PSUM_W       = 16;

  typedef logic signed [PSUM_W-1:0] int16_t;

  // Storage layout of one aligned row: column data above a single last-of-tile bit.
  typedef struct packed {
    int16_t [SA_N_DEFAULT-1:0] data;
    logic                      last;
  } psum_row_t;

endpackage

// File: rtl/sa_psum_drain_if.sv
// Array-facing psum inputs and the downstream aligned-row stream of the drain.
interface sa_psum_drain_if #(
  parameter int N = sa_psum_drain_pkg::SA_N_DEFAULT
) ();
  import sa_psum_drain_pkg::*;

  logic           col0_valid_i;
  int16_t [N-1:0] psum_i;
  int16_t [N-1:0] row_data_o;
  logic           row_valid_o;
  logic           row_ready_i;
  logic           row_last_o;

  // Row stream: a row transfers on a cycle where row_valid_o & row_ready_i; while
  // row_valid_o=1 & !row_ready_i, row_data_o/row_last_o hold. The psum side has no
  // backpressure.
  modport slave (
    input  col0_valid_i, psum_i, row_ready_i,
    output row_data_o, row_valid_o, row_last_o
  );

  modport master (
    output col0_valid_i, psum_i, row_ready_i,
    input  row_data_o, row_valid_o, row_last_o
  );

endinterface

// File: rtl/sa_row_fifo.sv
// Synchronous FIFO with exact occupancy count; a write to an empty FIFO is only
// visible on the read side the following cycle.
module sa_row_fifo #(
  parameter int  W     = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_rd = rd_en_i & ~empty_o;
  assign do_wr = wr_en_i & (~full_o | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/sa_psum_drain.sv
// Deskews skewed column psums into aligned rows, tags tile boundaries and buffers
// rows for a ready/valid consumer; rows arriving to a full buffer are dropped.
module sa_psum_drain
  import sa_psum_drain_pkg::*;
#(
  parameter int  N             = SA_N_DEFAULT,
  parameter int  FIFO_DEPTH    = 4,
  parameter int  ROWS_PER_TILE = 4,
  localparam int CW            = $clog2(FIFO_DEPTH) + 1,
  localparam int TCW           = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1,
  localparam int RW            = N * PSUM_W + 1
) (
  input  logic           clk_i,
  input  logic           reset,
  sa_psum_drain_if.slave bus,
  output logic [CW-1:0]  fifo_count_o,
  output logic           overflow_o
);

  int16_t          aligned [N];
  logic [N-2:0]    vld_q;
  logic            push;
  logic [TCW-1:0]  row_cnt_q, row_cnt_d;
  logic            tile_last;
  logic            overflow_q, overflow_d;
  logic [RW-1:0]   wr_row, rd_row;
  logic            fifo_full, fifo_empty, pop;

  // Column j arrives j cycles late, so it waits N-1-j cycles to line up with column N-1.
  for (genvar j = 0; j < N - 1; j++) begin : g_dly
    int16_t stage_q [N-1-j];
    always_ff @(posedge clk_i) begin
      if (reset) begin
        for (int k = 0; k < N - 1 - j; k++) stage_q[k] <= '0;
      end else begin
        stage_q[0] <= bus.psum_i[j];
        for (int k = 1; k < N - 1 - j; k++) stage_q[k] <= stage_q[k-1];
      end
    end
    assign aligned[j] = stage_q[N-2-j];
  end
  assign aligned[N-1] = bus.psum_i[N-1];

  always_ff @(posedge clk_i) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= bus.col0_valid_i;
      for (int k = 1; k < N - 1; k++) vld_q[k] <= vld_q[k-1];
    end
  end
  assign push = vld_q[N-2];

  // Framing counts every formed row, dropped or not, so tile boundaries never slip.
  assign tile_last = (row_cnt_q == TCW'(ROWS_PER_TILE - 1));
  assign pop       = ~fifo_empty & bus.row_ready_i;

  always_comb begin
    row_cnt_d  = row_cnt_q;
    overflow_d = overflow_q;
    if (push) begin
      row_cnt_d = tile_last ? '0 : row_cnt_q + TCW'(1);
      if (fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      row_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      row_cnt_q  <= row_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    wr_row = '0;
    for (int j = 0; j < N; j++) wr_row[1 + j*PSUM_W +: PSUM_W] = aligned[j];
    wr_row[0] = tile_last;
  end

  sa_row_fifo #(
    .W     (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset     (reset),
    .wr_en_i   (push),
    .wr_data_i (wr_row),
    .rd_en_i   (bus.row_ready_i),
    .rd_data_o (rd_row),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count_o)
  );

  // Outputs read zero while empty so stale storage never shows after reset.
  always_comb begin
    bus.row_data_o = '0;
    bus.row_last_o = 1'b0;
    if (!fifo_empty) begin
      for (int j = 0; j < N; j++) bus.row_data_o[j] = rd_row[1 + j*PSUM_W +: PSUM_W];
      bus.row_last_o = rd_row[0];
    end
  end

  assign bus.row_valid_o = ~fifo_empty;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_sa_psum_drain.sv
// Directed bench for sa_psum_drain: skewed stimulus driver, expected-row queue and monitor.
module tb_sa_psum_drain;
  import sa_psum_drain_pkg::*;

  localparam int N   = 4;
  localparam int FD  = 4;
  localparam int RPT = 4;
  localparam int RW  = N * 16 + 1;
  localparam int CW  = $clog2(FD) + 1;

  logic          clk;
  logic          reset;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  sa_psum_drain_if #(.N(N)) bus ();

  sa_psum_drain #(
    .N             (N),
    .FIFO_DEPTH    (FD),
    .ROWS_PER_TILE (RPT)
  ) dut (
    .clk_i        (clk),
    .reset        (reset),
    .bus          (bus),
    .fifo_count_o (fifo_count),
    .overflow_o   (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_exp;
  int16_t        rows_mem [0:31][0:N-1];
  int            tile_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.col0_valid_i = 1'b0;
    bus.row_ready_i  = 1'b0;
    bus.psum_i       = '0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    tile_cnt = 0;
    exp_q.delete();
  endtask

  task automatic set_row(input int idx, input int16_t a, input int16_t b,
                         input int16_t c, input int16_t d);
    rows_mem[idx][0] = a;
    rows_mem[idx][1] = b;
    rows_mem[idx][2] = c;
    rows_mem[idx][3] = d;
  endtask

  // ---------------- driver ----------------
  // Issues rows base..base+n-1 with the column skew; only the first keep rows are expected out.
  task automatic send_burst(input int n, input int base, input int keep);
    logic [RW-1:0] w;
    for (int c = 0; c < n + N - 1; c++) begin
      bus.col0_valid_i = (c < n);
      for (int j = 0; j < N; j++) begin
        int r;
        r = c - j;
        if (r >= 0 && r < n) bus.psum_i[j] = rows_mem[base + r][j];
        else                 bus.psum_i[j] = int16_t'($urandom_range(0, 65535));
      end
      if (c < n) begin
        w = '0;
        for (int j = 0; j < N; j++) w[1 + j*16 +: 16] = rows_mem[base + c][j];
        w[0]     = (tile_cnt == RPT - 1);
        tile_cnt = (tile_cnt == RPT - 1) ? 0 : tile_cnt + 1;
        if (c < keep) exp_q.push_back(w);
      end
      sync();
    end
    bus.col0_valid_i = 1'b0;
  endtask

  task automatic watch_valid(input int lo, input int hi, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check($sformatf("valid_cyc%0d", c), 128'(bus.row_valid_o), 128'(c >= lo && c <= hi));
    end
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && bus.row_valid_o && bus.row_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_row: got %h expected none at %0t",
                 {bus.row_data_o, bus.row_last_o}, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("row", 128'({bus.row_data_o, bus.row_last_o}), 128'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    set_row(0,  10,  20,  30,  40);
    set_row(1,   1,   2,   3,   4);
    set_row(2,  -5,   6,  -7,   8);
    set_row(3, 100, 200, 300, 400);
    set_row(4, 111, 222, 333, 444);
    for (int i = 5; i < 10; i++) set_row(i, int16_t'(i), int16_t'(-i), int16_t'(i*3), int16_t'(1000+i));
    for (int i = 10; i < 15; i++) set_row(i, int16_t'(i*7), int16_t'(i), int16_t'(-2*i), int16_t'(i+50));
    set_row(15, 9, 9, 9, 9);
    set_row(16, -32768, 32767, -1, 0);
    set_row(17, 0, -1, 32767, -32768);
    set_row(18, -32768, -32768, -32768, -32768);
    set_row(19, 32767, 32767, 32767, 32767);
    set_row(20, -1, -1, -1, -1);
    set_row(21, 1, -2, 3, -4);
    set_row(22, -32767, 32766, 2, -2);
    set_row(23, 12345, -12345, 4660, -4660);

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_valid", 128'(bus.row_valid_o), 128'(0));
    check("rst_last",  128'(bus.row_last_o),  128'(0));
    check("rst_count", 128'(fifo_count),      128'(0));
    check("rst_ovf",   128'(overflow),        128'(0));
    check("rst_data",  128'(bus.row_data_o),  128'(0));

    // 1: single row, latency N
    bus.row_ready_i = 1'b1;
    sync();
    fork
      send_burst(1, 0, 1);
      watch_valid(4, 4, 8);
    join
    drain_wait();

    // 2: four back-to-back rows, last on the fourth
    do_reset();
    bus.row_ready_i = 1'b1;
    fork
      send_burst(4, 1, 4);
      watch_valid(4, 7, 10);
    join
    drain_wait();

    // 3: stalled consumer, fifth row dropped
    do_reset();
    send_burst(5, 5, 4);
    @(negedge clk);
    check("ovf_count", 128'(fifo_count), 128'(4));
    check("ovf_flag",  128'(overflow),   128'(1));
    sync();
    bus.row_ready_i = 1'b1;
    drain_wait();
    check("ovf_sticky", 128'(overflow),   128'(1));
    check("ovf_empty",  128'(fifo_count), 128'(0));

    // 4: push and pop in the same cycle while full
    do_reset();
    fork
      send_burst(5, 10, 5);
      begin
        repeat (7) @(posedge clk);
        #1 bus.row_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.row_ready_i = 1'b0;
        @(negedge clk);
        check("full_pp_count", 128'(fifo_count), 128'(4));
        check("full_pp_ovf",   128'(overflow),   128'(0));
      end
    join
    sync();
    bus.row_ready_i = 1'b1;
    drain_wait();
    check("full_pp_ovf_end", 128'(overflow), 128'(0));

    // 5: reset mid-flight discards the row
    do_reset();
    bus.row_ready_i = 1'b1;
    fork
      send_burst(1, 15, 0);
      begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end
      watch_valid(99, 99, 11);
    join
    check("midrst_count", 128'(fifo_count),     128'(0));
    check("midrst_ovf",   128'(overflow),       128'(0));
    check("midrst_last",  128'(bus.row_last_o), 128'(0));
    check("midrst_data",  128'(bus.row_data_o), 128'(0));

    // 6: extreme values over two tiles
    do_reset();
    bus.row_ready_i = 1'b1;
    fork
      send_burst(8, 16, 8);
      watch_valid(4, 11, 14);
    join
    drain_wait();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
